accum_window_ctrl: RTL and testbench

Drives the 28-bit sample accumulator from the far side of its `A`/`ce`/`rst` interface. It accepts a stream of 10-bit skin-sensor samples and feeds exactly 2^LOG2_N of them into the accumulator per window. At the end of each window it reads the sum back, rounds it to a 10-bit mean, and presents the mean on a valid/ready output, then clears the accumulator for the next window. It sits between the sensor sample front-end and the neuron input layer.

---
 rtl/accum_pkg.sv | 15 +
 rtl/mean_round.sv | 21 ++
 rtl/accum_window_ctrl.sv | 96 +++++++++
 tb/tb_accum_window_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator window controller.
package accum_pkg;

  typedef enum logic [1:0] {StClear, StAccum, StDrain} state_e;

  localparam int unsigned IN_W_DEF  = 10;
  localparam int unsigned ACC_W_DEF = 28;
  localparam int unsigned OUT_W_DEF = 10;

  // Largest L such that 2^L full-scale samples still fit in acc_w bits.
  function automatic int unsigned max_log2_n(input int unsigned acc_w, input int unsigned in_w);
    return acc_w - in_w;
  endfunction

endpackage

// File: rtl/mean_round.sv
// Window mean: add half an LSB, shift by LOG2_N, saturate to OUT_W bits.
module mean_round #(
  parameter int unsigned ACC_W  = 28,
  parameter int unsigned LOG2_N = 6,
  parameter int unsigned OUT_W  = 10
) (
  input  logic [ACC_W-1:0] sum,
  output logic [OUT_W-1:0] mean
);

  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (LOG2_N - 1);

  logic [ACC_W:0] rounded;
  logic [ACC_W:0] shifted;

  // One extra bit so the rounding add cannot wrap.
  assign rounded = {1'b0, sum} + HALF;
  assign shifted = rounded >> LOG2_N;
  assign mean    = (|shifted[ACC_W:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

endmodule

// File: rtl/accum_window_ctrl.sv
// Feeds 2^LOG2_N samples per window into an external accumulator and emits the rounded mean.
module accum_window_ctrl import accum_pkg::*; #(
  parameter int unsigned LOG2_N = 6,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [IN_W-1:0]  acc_a,
  output logic             acc_ce,
  output logic             acc_clr,
  input  logic [ACC_W-1:0] acc_y,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             stall
);

  state_e            state_q, state_d;
  logic [LOG2_N-1:0] cnt_q;
  logic [OUT_W-1:0]  m_data_q;
  logic              m_valid_q;
  logic [OUT_W-1:0]  mean;
  logic              accept;
  logic              load;
  logic              clr_fsm;

  mean_round #(
    .ACC_W  (ACC_W),
    .LOG2_N (LOG2_N),
    .OUT_W  (OUT_W)
  ) u_mean_round (
    .sum  (acc_y),
    .mean (mean)
  );

  assign accept  = s_valid & s_ready;
  assign acc_ce  = accept;
  assign acc_a   = s_data;
  // Combinational so the accumulator clears on the same edge as this block.
  assign acc_clr = rst | clr_fsm;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    stall   = 1'b0;
    load    = 1'b0;
    clr_fsm = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_fsm = 1'b1;
        state_d = StAccum;
      end
      StAccum: begin
        s_ready = 1'b1;
        if (accept && (&cnt_q)) state_d = StDrain;
      end
      StDrain: begin
        if (!m_valid_q || m_ready) begin
          load    = 1'b1;
          clr_fsm = 1'b1;
          state_d = StAccum;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter wraps to zero on the last accept of a window.
      if (accept) cnt_q <= cnt_q + LOG2_N'(1);
      if (load) begin
        m_data_q  <= mean;
        m_valid_q <= 1'b1;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accum_window_ctrl.sv
// Bench for accum_window_ctrl with a behavioural accumulator, LOG2_N=2 (N=4).
module tb_accum_window_ctrl;

  localparam int unsigned LOG2_N = 2;
  localparam int unsigned IN_W   = 10;
  localparam int unsigned ACC_W  = 28;
  localparam int unsigned OUT_W  = 10;
  localparam int NV = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  s_data;
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  acc_a;
  logic             acc_ce;
  logic             acc_clr;
  logic [ACC_W-1:0] acc_y;
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             stall;

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] got_q[$];

  typedef struct packed {
    logic [3:0][IN_W-1:0] smp;
    logic [ACC_W-1:0]     sum;
    logic [OUT_W-1:0]     mean;
  } vec_t;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  accum_window_ctrl #(
    .LOG2_N (LOG2_N),
    .IN_W   (IN_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .acc_a   (acc_a),
    .acc_ce  (acc_ce),
    .acc_clr (acc_clr),
    .acc_y   (acc_y),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .stall   (stall)
  );

  // Accumulator model: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (acc_clr) acc_y <= '0;
    else if (acc_ce) acc_y <= acc_y + {{(ACC_W - IN_W){1'b0}}, acc_a};
  end

  // Record each delivered mean; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back(m_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_window(input logic [3:0][IN_W-1:0] w);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = w[i];
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    step();
    step();
    check("rst_s_ready", s_ready, 0);
    check("rst_acc_ce", acc_ce, 0);
    check("rst_acc_clr", acc_clr, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;
    #1;
    check("clear_s_ready", s_ready, 0);
    check("clear_acc_clr", acc_clr, 1);
    step();
    check("first_s_ready", s_ready, 1);
    check("first_acc_clr", acc_clr, 0);
  endtask

  initial begin
    vecs[0].smp = {10'd4, 10'd3, 10'd2, 10'd1};        vecs[0].sum = 10;   vecs[0].mean = 3;
    vecs[1].smp = {10'd1023, 10'd1023, 10'd1023, 10'd1023};
    vecs[1].sum = 4092; vecs[1].mean = 1023;
    vecs[2].smp = {10'd2, 10'd1, 10'd1, 10'd1};        vecs[2].sum = 5;    vecs[2].mean = 1;
    vecs[3].smp = {10'd1, 10'd0, 10'd0, 10'd0};        vecs[3].sum = 1;    vecs[3].mean = 0;
    vecs[4].smp = {10'd2, 10'd0, 10'd0, 10'd0};        vecs[4].sum = 2;    vecs[4].mean = 1;
    vecs[5].smp = {10'd6, 10'd5, 10'd5, 10'd5};        vecs[5].sum = 21;   vecs[5].mean = 5;

    reset_dut();

    // Back-to-back windows with m_ready high: N samples per N+1 cycles.
    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < 4; i++) begin
        s_valid = 1'b1;
        s_data  = vecs[v].smp[i];
        #1;
        check("accum_s_ready", s_ready, 1);
        check("accum_acc_ce", acc_ce, 1);
        check("accum_acc_a", acc_a, s_data);
        if (i == 0 && v > 0) begin
          check("vec_m_valid", m_valid, 1);
          check("vec_m_data", m_data, vecs[v-1].mean);
        end
        step();
      end
      s_valid = 1'b0;
      #1;
      check("drain_s_ready", s_ready, 0);
      check("drain_acc_clr", acc_clr, 1);
      check("drain_stall", stall, 0);
      check("drain_acc_y", acc_y, vecs[v].sum);
      step();
    end
    check("last_m_valid", m_valid, 1);
    check("last_m_data", m_data, vecs[NV-1].mean);
    step();
    check("last_m_valid_clr", m_valid, 0);

    // Backpressure across two windows.
    got_q.delete();
    m_ready = 1'b0;
    send_window({10'd4, 10'd3, 10'd2, 10'd1});
    step();
    check("bp_first_valid", m_valid, 1);
    check("bp_first_data", m_data, 3);
    send_window({10'd5, 10'd5, 10'd5, 10'd5});
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_stall", stall, 1);
      check("bp_s_ready", s_ready, 0);
      check("bp_acc_clr", acc_clr, 0);
      check("bp_acc_y", acc_y, 20);
      check("bp_hold_data", m_data, 3);
      check("bp_hold_valid", m_valid, 1);
      step();
    end
    m_ready = 1'b1;
    #1;
    check("bp_release_stall", stall, 0);
    check("bp_release_clr", acc_clr, 1);
    step();
    check("bp_second_valid", m_valid, 1);
    check("bp_second_data", m_data, 5);
    step();
    check("bp_drained", m_valid, 0);
    check("bp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("bp_out0", got_q[0], 3);
      check("bp_out1", got_q[1], 5);
    end

    // DRAIN coincides with handshake of the previous mean: no bubble.
    m_ready = 1'b0;
    send_window({10'd2, 10'd2, 10'd2, 10'd2});
    step();
    send_window({10'd7, 10'd7, 10'd7, 10'd7});
    m_ready = 1'b1;
    #1;
    check("nb_stall", stall, 0);
    check("nb_acc_clr", acc_clr, 1);
    check("nb_old_valid", m_valid, 1);
    check("nb_old_data", m_data, 2);
    step();
    check("nb_new_valid", m_valid, 1);
    check("nb_new_data", m_data, 7);
    step();
    check("nb_clr_valid", m_valid, 0);

    // Reset mid-window with a pending output.
    m_ready = 1'b0;
    send_window({10'd3, 10'd3, 10'd3, 10'd3});
    step();
    s_valid = 1'b1; s_data = 10'd7; step();
    s_data = 10'd9; step();
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_acc_clr", acc_clr, 1);
    step();
    check("mr_m_valid", m_valid, 0);
    check("mr_m_data", m_data, 0);
    check("mr_acc_y", acc_y, 0);
    check("mr_s_ready", s_ready, 0);
    rst = 1'b0;
    m_ready = 1'b1;
    step();
    send_window({10'd4, 10'd4, 10'd4, 10'd4});
    #1;
    check("mr_sum", acc_y, 16);
    step();
    check("mr_valid", m_valid, 1);
    check("mr_data", m_data, 4);
    step();

    // Gapped input: one sample every 3 cycles.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = IN_W'(10 + i);
      #1;
      check("gap_acc_ce_on", acc_ce, 1);
      check("gap_s_ready_on", s_ready, 1);
      step();
      s_valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          #1;
          check("gap_acc_ce_off", acc_ce, 0);
          check("gap_s_ready_idle", s_ready, 1);
          step();
        end
      end
    end
    #1;
    check("gap_drain_ready", s_ready, 0);
    check("gap_sum", acc_y, 46);
    step();
    check("gap_valid", m_valid, 1);
    check("gap_data", m_data, 12);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
